nitta_to_spi_frame_splitter: RTL and testbench



---
 rtl/nitta_spi_pkg.sv | 10 +
 rtl/nitta_to_spi_frame_splitter_if.sv | 22 ++
 rtl/nitta_spi_ready_edge.sv | 14 +
 rtl/nitta_to_spi_frame_splitter.sv | 99 +++++++++
 tb/tb_nitta_to_spi_frame_splitter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/nitta_spi_pkg.sv
// nitta_spi_pkg: shared helpers and state encoding for the NITTA<->SPI splitter and gatherer
package nitta_spi_pkg;
    typedef enum logic {LOAD, SEND} state_t;
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/nitta_to_spi_frame_splitter_if.sv
// nitta_to_spi_frame_splitter_if: NITTA word load handshake plus SPI subframe side
interface nitta_to_spi_frame_splitter_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8
);
    logic                      word_valid;
    logic [DATA_WIDTH-1:0]     word_in;
    logic                      word_ready;
    logic                      spi_ready;
    logic [SPI_DATA_WIDTH-1:0] to_spi;
    logic                      busy;
    logic                      frame_done;
    logic                      underrun;
    modport master (
        output word_valid, word_in, spi_ready,
        input  word_ready, to_spi, busy, frame_done, underrun
    );
    modport slave (
        input  word_valid, word_in, spi_ready,
        output word_ready, to_spi, busy, frame_done, underrun
    );
endinterface

// File: rtl/nitta_spi_ready_edge.sv
// nitta_spi_ready_edge: rising-edge detector on spi_ready; a level already high at reset release is not an edge
module nitta_spi_ready_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_spi_ready,
    output logic o_edge
);
    logic r_spi_ready_q;
    // Reset also preloads the current level, so the register is loaded identically in both cases
    always_ff @(posedge clk) begin
        r_spi_ready_q <= i_spi_ready;
    end
    assign o_edge = i_spi_ready && !r_spi_ready_q && !rst;
endmodule

// File: rtl/nitta_to_spi_frame_splitter.sv
// nitta_to_spi_frame_splitter: buffers WORDS NITTA words and streams them as SPI_DATA_WIDTH subframes
module nitta_to_spi_frame_splitter
    import nitta_spi_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int WORDS          = 4,
    parameter bit MSB_FIRST      = 1'b1
) (
    input logic clk,
    input logic rst,
    nitta_to_spi_frame_splitter_if.slave bus
);
    localparam int SUBFRAMES = ceil_div(DATA_WIDTH, SPI_DATA_WIDTH);
    localparam int PAD_WIDTH = SUBFRAMES * SPI_DATA_WIDTH;
    localparam int WC_W      = clog2_min1(WORDS);
    localparam int SC_W      = clog2_min1(SUBFRAMES);
    localparam logic [WC_W-1:0] W_LAST = WC_W'(WORDS - 1);
    localparam logic [SC_W-1:0] S_LAST = SC_W'(SUBFRAMES - 1);

    state_t                    r_state, w_state_nxt;
    logic [WC_W-1:0]           r_word_cnt, w_word_nxt;
    logic [SC_W-1:0]           r_sub_cnt, w_sub_nxt, w_k;
    logic [DATA_WIDTH-1:0]     r_buf [WORDS];
    logic [DATA_WIDTH-1:0]     w_buf_nxt [WORDS];
    logic [PAD_WIDTH-1:0]      w_pad;
    logic [SPI_DATA_WIDTH-1:0] r_to_spi, w_sub;
    logic                      r_frame_done, r_underrun, w_done, w_under, w_edge;

    nitta_spi_ready_edge u_edge (
        .clk        (clk),
        .rst        (rst),
        .i_spi_ready(bus.spi_ready),
        .o_edge     (w_edge)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word_cnt;
        w_sub_nxt   = r_sub_cnt;
        w_buf_nxt   = r_buf;
        w_done      = 1'b0;
        w_under     = 1'b0;
        if (r_state == LOAD) begin
            w_under = w_edge;
            if (bus.word_valid) begin
                w_buf_nxt[r_word_cnt] = bus.word_in;
                w_word_nxt  = (r_word_cnt == W_LAST) ? '0 : r_word_cnt + 1'b1;
                w_state_nxt = (r_word_cnt == W_LAST) ? SEND : LOAD;
            end
        end else if (w_edge) begin
            if (r_sub_cnt != S_LAST) begin
                w_sub_nxt = r_sub_cnt + 1'b1;
            end else if (r_word_cnt != W_LAST) begin
                w_sub_nxt  = '0;
                w_word_nxt = r_word_cnt + 1'b1;
            end else begin
                w_done      = 1'b1;
                w_sub_nxt   = '0;
                w_word_nxt  = '0;
                w_state_nxt = LOAD;
            end
        end
    end

    // to_spi is registered from next-state values so it tracks load and advance with one-cycle latency
    always_comb begin
        w_pad = '0;
        w_pad[DATA_WIDTH-1:0] = w_buf_nxt[w_word_nxt];
        w_k   = MSB_FIRST ? S_LAST - w_sub_nxt : w_sub_nxt;
        w_sub = w_pad[w_k*SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= LOAD;
            r_word_cnt   <= '0;
            r_sub_cnt    <= '0;
            r_buf        <= '{default: '0};
            r_to_spi     <= '0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_word_cnt   <= w_word_nxt;
            r_sub_cnt    <= w_sub_nxt;
            r_buf        <= w_buf_nxt;
            r_to_spi     <= (w_state_nxt == SEND) ? w_sub : '0;
            r_frame_done <= w_done;
            r_underrun   <= w_under;
        end
    end

    assign bus.word_ready = (r_state == LOAD);
    assign bus.busy       = (r_state == SEND);
    assign bus.to_spi     = r_to_spi;
    assign bus.frame_done = r_frame_done;
    assign bus.underrun   = r_underrun;
endmodule

// File: tb/tb_nitta_to_spi_frame_splitter.sv
// tb_nitta_to_spi_frame_splitter: three configurations share one stimulus stream; a subframe-queue model feeds a per-cycle scoreboard
module tb_nitta_to_spi_frame_splitter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        word_valid = 1'b0;
    logic        spi_ready = 1'b0;
    logic [31:0] word_in = '0;

    always #5 clk = ~clk;

    // a: 32/8/2 MSB first, b: 32/8/2 LSB first, c: 12/8/1 MSB first (padded top subframe)
    localparam int DW [3] = '{32, 32, 12};
    localparam int NW [3] = '{2, 2, 1};
    localparam bit MF [3] = '{1'b1, 1'b0, 1'b1};

    nitta_to_spi_frame_splitter_if #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8)) if_a ();
    nitta_to_spi_frame_splitter_if #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8)) if_b ();
    nitta_to_spi_frame_splitter_if #(.DATA_WIDTH(12), .SPI_DATA_WIDTH(8)) if_c ();

    assign if_a.word_valid = word_valid;
    assign if_b.word_valid = word_valid;
    assign if_c.word_valid = word_valid;
    assign if_a.word_in    = word_in;
    assign if_b.word_in    = word_in;
    assign if_c.word_in    = word_in[11:0];
    assign if_a.spi_ready  = spi_ready;
    assign if_b.spi_ready  = spi_ready;
    assign if_c.spi_ready  = spi_ready;

    nitta_to_spi_frame_splitter #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8), .WORDS(2), .MSB_FIRST(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    nitta_to_spi_frame_splitter #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8), .WORDS(2), .MSB_FIRST(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    nitta_to_spi_frame_splitter #(.DATA_WIDTH(12), .SPI_DATA_WIDTH(8), .WORDS(1), .MSB_FIRST(1'b1))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));

    logic [7:0] o_spi [3];
    logic [2:0] o_busy, o_ready, o_done, o_und;
    assign o_spi[0] = if_a.to_spi;
    assign o_spi[1] = if_b.to_spi;
    assign o_spi[2] = if_c.to_spi;
    assign o_busy   = {if_c.busy, if_b.busy, if_a.busy};
    assign o_ready  = {if_c.word_ready, if_b.word_ready, if_a.word_ready};
    assign o_done   = {if_c.frame_done, if_b.frame_done, if_a.frame_done};
    assign o_und    = {if_c.underrun, if_b.underrun, if_a.underrun};

    typedef struct packed {
        logic [2:0][7:0] spi;
        logic [2:0]      busy;
        logic [2:0]      done;
        logic [2:0]      und;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   checks = 0;
    int   failures = 0;

    // Model: a frame, once fully loaded, becomes a flat queue of subframes; each SPI edge consumes one
    logic [31:0] m_words [3][4];
    logic [7:0]  m_fifo [3][8];
    int          m_nl [3];
    int          m_head [3];
    int          m_cnt [3];
    logic        m_prev = 1'b0;

    task automatic step(input logic r, input logic wv, input logic [31:0] wd, input logic sp);
        exp_t e;
        logic edge_now;
        int   s;
        logic [31:0] w;
        @(negedge clk);
        rst = r;
        word_valid = wv;
        word_in = wd;
        spi_ready = sp;
        edge_now = sp && !m_prev;
        m_prev = sp;
        e = '0;
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                m_cnt[i] = 0;
                m_head[i] = 0;
                m_nl[i] = 0;
            end else if (m_cnt[i] > 0) begin
                if (edge_now) begin
                    m_head[i]++;
                    m_cnt[i]--;
                    e.done[i] = (m_cnt[i] == 0);
                end
            end else begin
                e.und[i] = edge_now;
                if (wv) begin
                    m_words[i][m_nl[i]] = wd & 32'((64'd1 << DW[i]) - 64'd1);
                    m_nl[i]++;
                    if (m_nl[i] == NW[i]) begin
                        s = (DW[i] + 7) / 8;
                        for (int k = 0; k < NW[i]; k++) begin
                            for (int j = 0; j < s; j++) begin
                                w = m_words[i][k] >> (8 * (MF[i] ? s - 1 - j : j));
                                m_fifo[i][k * s + j] = w[7:0];
                            end
                        end
                        m_cnt[i] = NW[i] * s;
                        m_head[i] = 0;
                        m_nl[i] = 0;
                    end
                end
            end
            e.busy[i] = (m_cnt[i] > 0);
            e.spi[i] = e.busy[i] ? m_fifo[i][m_head[i]] : 8'h00;
        end
        sb.push_back(e);
    endtask

    task automatic pulse(input logic wv, input logic [31:0] wd);
        step(1'b0, wv, wd, 1'b1);
        step(1'b0, wv, wd, 1'b0);
    endtask

    task automatic load2(input logic [31:0] a, input logic [31:0] b);
        step(1'b0, 1'b1, a, 1'b0);
        step(1'b0, 1'b1, b, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic chk(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[dut%0d] actual=%h expected=%h at %0t", name, i, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            m_e = sb.pop_front();
            for (int i = 0; i < 3; i++) begin
                chk("to_spi", i, o_spi[i], m_e.spi[i]);
                chk("busy", i, {7'd0, o_busy[i]}, {7'd0, m_e.busy[i]});
                chk("word_ready", i, {7'd0, o_ready[i]}, {7'd0, !m_e.busy[i]});
                chk("frame_done", i, {7'd0, o_done[i]}, {7'd0, m_e.done[i]});
                chk("underrun", i, {7'd0, o_und[i]}, {7'd0, m_e.und[i]});
            end
        end
    end

    initial begin
        repeat (3) step(1'b1, 1'b0, '0, 1'b0);
        // frame of two words, 8 minimum-spaced edges, then one spare edge (underrun)
        load2(32'hA1B2C3D4, 32'h11223344);
        repeat (9) pulse(1'b0, '0);
        // 12-bit word in dut c: 0x0A then 0xBC
        step(1'b0, 1'b1, 32'h00000ABC, 1'b0);
        repeat (3) pulse(1'b0, '0);
        // spi_ready high through reset release, then one genuine edge
        repeat (3) step(1'b1, 1'b0, '0, 1'b1);
        repeat (3) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);
        pulse(1'b0, '0);
        repeat (2) step(1'b0, 1'b0, '0, 1'b0);
        // reset mid-frame then reload
        load2(32'hA1B2C3D4, 32'h11223344);
        repeat (3) pulse(1'b0, '0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        load2(32'h55667788, 32'h99AABBCC);
        repeat (8) pulse(1'b0, '0);
        // word_valid held through SEND
        step(1'b1, 1'b0, '0, 1'b0);
        load2(32'hA1B2C3D4, 32'h11223344);
        repeat (10) pulse(1'b1, 32'hDEADBEEF);
        repeat (4) step(1'b0, 1'b0, '0, 1'b0);
        repeat (3000) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 99) < 35);
        end
        repeat (3) step(1'b0, 1'b0, '0, 1'b0);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
